// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: counters, sync, one-cycle-lead pixel requests and colour gating.
// Optional `VGA_BORDER_EN forces the outer 1-pixel ring of the active window to white.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_VALID  = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_VALID  = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start,
    output logic        line_end
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_E  = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_S  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_E  = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [9:0] H_REQ_S  = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_E  = 10'(H_SYNC + H_BACK + H_VALID - 1);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       v_act;
    logic       h_act;
    logic       h_req;

    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    // Requests run one clock ahead of the display window so the registered
    // colour from the generator lands exactly on the matching pixel.
    always_comb begin
        v_act     = (cnt_v >= V_ACT_S) && (cnt_v < V_ACT_E);
        h_act     = (cnt_h >= H_ACT_S) && (cnt_h < H_ACT_E);
        h_req     = (cnt_h >= H_REQ_S) && (cnt_h < H_REQ_E);
        rgb_valid = h_act && v_act;
        pix_req   = h_req && v_act;
        pix_x     = pix_req ? (cnt_h - H_REQ_S) : '1;
        pix_y     = pix_req ? (cnt_v - V_ACT_S) : '1;
    end

    always_comb begin
        hsync       = (cnt_h < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        vsync       = (cnt_v < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        frame_start = (cnt_h == '0) && (cnt_v == '0);
        line_end    = (cnt_h == H_LAST);
    end

`ifdef VGA_BORDER_EN
    logic on_border;

    always_comb begin
        on_border = (cnt_h == H_ACT_S) || (cnt_h == H_ACT_E - 10'd1) ||
                    (cnt_v == V_ACT_S) || (cnt_v == V_ACT_E - 10'd1);
        if (!rgb_valid)
            rgb = '0;
        else if (on_border)
            rgb = '1;
        else
            rgb = pix_data;
    end
`else
    always_comb begin
        rgb = rgb_valid ? pix_data : '0;
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance with a registered pattern generator
// and a shrunken active-high-sync instance with random data and random async resets.
module tb_vga_timing_ctrl;

    typedef struct {
        int   hs, hb, hv, hf, vs, vb, vv, vf;
        logic pol;
    } cfg_t;

    typedef struct {
        int         h;
        int         v;
        logic [9:0] px;
        logic [9:0] py;
        logic       req, valid, hs, vs, fs, le;
    } vec_t;

    cfg_t cfg0 = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b0};
    cfg_t cfg1 = '{4, 3, 10, 2, 2, 2, 5, 1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0, rst1 = 1'b0;
    logic [15:0] pd0 = '0, pd1 = '0;

    logic [9:0]  x0, y0, x1, y1;
    logic        req0, hs0, vs0, val0, fs0, le0;
    logic        req1, hs1, vs1, val1, fs1, le1;
    logic [15:0] rgb0, rgb1;

    int unsigned t0 = 0, t1 = 0;
    int          n_pass = 0, n_total = 0;

    vga_timing_ctrl u_dut0 (
        .Clk_int(clk), .Sys_Rst_n(rst0), .pix_data(pd0),
        .pix_x(x0), .pix_y(y0), .pix_req(req0), .hsync(hs0), .vsync(vs0),
        .rgb(rgb0), .rgb_valid(val0), .frame_start(fs0), .line_end(le0)
    );

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VALID(5), .V_FRONT(1),
        .SYNC_POL(1'b1)
    ) u_dut1 (
        .Clk_int(clk), .Sys_Rst_n(rst1), .pix_data(pd1),
        .pix_x(x1), .pix_y(y1), .pix_req(req1), .hsync(hs1), .vsync(vs1),
        .rgb(rgb1), .rgb_valid(val1), .frame_start(fs1), .line_end(le1)
    );

    // Downstream generator: registered colour for the requested coordinate.
    always @(posedge clk) pd0 <= {x0[4:0], y0[5:0], x0[4:0]};

    // Model time since reset; position is derived by division, not counting.
    always @(posedge clk or negedge rst0)
        if (!rst0) t0 <= 0; else t0 <= t0 + 1;
    always @(posedge clk or negedge rst1)
        if (!rst1) t1 <= 0; else t1 <= t1 + 1;

    initial forever begin
        @(negedge clk);
        pd1 = 16'($urandom);
    end

    function automatic logic [41:0] model_out(cfg_t c, int unsigned t, logic [15:0] data, bit gen);
        int ht, vt, h, v, ha, va, dx, dy;
        logic [9:0]  px, py, dx10, dy10;
        logic        req, valid, hsy, vsy, fs, le;
        logic [15:0] col;
        ht    = c.hs + c.hb + c.hv + c.hf;
        vt    = c.vs + c.vb + c.vv + c.vf;
        h     = int'(t % ht);
        v     = int'((t / ht) % vt);
        ha    = c.hs + c.hb;
        va    = c.vs + c.vb;
        dx    = h - ha;
        dy    = v - va;
        valid = (dx >= 0) && (dx < c.hv) && (dy >= 0) && (dy < c.vv);
        req   = (dx >= -1) && (dx < c.hv - 1) && (dy >= 0) && (dy < c.vv);
        px    = req ? 10'(dx + 1) : 10'h3FF;
        py    = req ? 10'(dy) : 10'h3FF;
        hsy   = (h < c.hs) ? c.pol : ~c.pol;
        vsy   = (v < c.vs) ? c.pol : ~c.pol;
        fs    = (h == 0) && (v == 0);
        le    = (h == ht - 1);
        dx10  = 10'(dx);
        dy10  = 10'(dy);
        col   = gen ? {dx10[4:0], dy10[5:0], dx10[4:0]} : data;
`ifdef VGA_BORDER_EN
        if (dx == 0 || dx == c.hv - 1 || dy == 0 || dy == c.vv - 1)
            col = 16'hFFFF;
`endif
        if (!valid)
            col = 16'h0000;
        return {px, py, req, hsy, vsy, valid, fs, le, col};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t0=%0d t1=%0d)", name, act, exp, t0, t1);
    endtask

    // Every cycle, both instances against the reference model.
    initial forever begin
        @(posedge clk);
        #2;
        chk("dut0 cycle", 64'({x0, y0, req0, hs0, vs0, val0, fs0, le0, rgb0}),
            64'(model_out(cfg0, t0, 16'h0000, 1'b1)));
        chk("dut1 cycle", 64'({x1, y1, req1, hs1, vs1, val1, fs1, le1, rgb1}),
            64'(model_out(cfg1, t1, pd1, 1'b0)));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached limit before completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_t0(input int unsigned target);
        int cyc = 0;
        while (t0 != target && cyc < 40000) begin
            @(posedge clk);
            #3;
            cyc++;
        end
        if (t0 != target)
            chk("wait timeout dut0", 64'(t0), 64'(target));
    endtask

    task automatic default_seq();
        vec_t vecs[$];
        int   n, m;
        vecs.push_back('{  0,  0, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{ 95,  0, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{ 96,  0, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{799,  0, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 0, 1});
        vecs.push_back('{  0,  1, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{  0,  2, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{143, 34, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{142, 35, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{143, 35, 10'd0,   10'd0,   1, 0, 1, 1, 0, 0});
        vecs.push_back('{144, 35, 10'd1,   10'd0,   1, 1, 1, 1, 0, 0});
        vecs.push_back('{782, 35, 10'd639, 10'd0,   1, 1, 1, 1, 0, 0});
        vecs.push_back('{783, 35, 10'h3FF, 10'h3FF, 0, 1, 1, 1, 0, 0});
        vecs.push_back('{784, 35, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{799, 35, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 0, 1});
        vecs.push_back('{143, 36, 10'd0,   10'd1,   1, 0, 1, 1, 0, 0});

        foreach (vecs[i]) begin
            wait_t0(int'(vecs[i].v * 800 + vecs[i].h));
            chk($sformatf("vec%0d pix_x", i),       64'(x0),   64'(vecs[i].px));
            chk($sformatf("vec%0d pix_y", i),       64'(y0),   64'(vecs[i].py));
            chk($sformatf("vec%0d pix_req", i),     64'(req0), 64'(vecs[i].req));
            chk($sformatf("vec%0d rgb_valid", i),   64'(val0), 64'(vecs[i].valid));
            chk($sformatf("vec%0d hsync", i),       64'(hs0),  64'(vecs[i].hs));
            chk($sformatf("vec%0d vsync", i),       64'(vs0),  64'(vecs[i].vs));
            chk($sformatf("vec%0d frame_start", i), 64'(fs0),  64'(vecs[i].fs));
            chk($sformatf("vec%0d line_end", i),    64'(le0),  64'(vecs[i].le));
        end

        // Mid-frame async reset, then a full sync pulse from the first clock.
        wait_t0(36 * 800 + 400);
        chk("pre-reset pix_req", 64'(req0), 64'(1));
        rst0 = 1'b0;
        #1;
        chk("async reset pix_req", 64'(req0), 64'(0));
        chk("async reset rgb", 64'(rgb0), 64'(0));
        chk("async reset rgb_valid", 64'(val0), 64'(0));
        chk("async reset pix_x", 64'(x0), 64'(10'h3FF));
        chk("async reset hsync", 64'(hs0), 64'(0));
        chk("async reset frame_start", 64'(fs0), 64'(1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        #3;
        chk("post-reset frame_start", 64'(fs0), 64'(1));
        n = 0;
        while (hs0 == 1'b0 && n < 1000) begin
            n++;
            @(posedge clk);
            #3;
        end
        chk("post-reset hsync low width", 64'(n), 64'(96));
        m = 0;
        while (hs0 == 1'b1 && m < 2000) begin
            m++;
            @(posedge clk);
            #3;
        end
        chk("hsync high width", 64'(m), 64'(704));
    endtask

    task automatic small_seq();
        int cyc, nval, nhs, nvs, nle, guard;
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(20, 300)) @(posedge clk);
            @(negedge clk);
            #1;
            rst1 = 1'b0;
            #1;
            chk("dut1 async reset", 64'({x1, y1, req1, hs1, vs1, val1, fs1, le1, rgb1}),
                64'(model_out(cfg1, 0, pd1, 1'b0)));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            @(negedge clk);
            rst1 = 1'b1;
        end
        for (int f = 0; f < 2; f++) begin
            guard = 0;
            do begin
                @(posedge clk);
                #3;
                guard++;
            end while (fs1 !== 1'b1 && guard < 400);
            chk("dut1 frame_start seen", 64'(fs1), 64'(1));
            cyc = 0; nval = 0; nhs = 0; nvs = 0; nle = 0;
            do begin
                cyc++;
                nval += int'(val1);
                nhs  += int'(hs1);
                nvs  += int'(vs1);
                nle  += int'(le1);
                @(posedge clk);
                #3;
            end while (fs1 !== 1'b1 && cyc < 1000);
            chk("dut1 frame period", 64'(cyc), 64'(190));
            chk("dut1 rgb_valid per frame", 64'(nval), 64'(50));
            chk("dut1 hsync asserted per frame", 64'(nhs), 64'(40));
            chk("dut1 vsync asserted per frame", 64'(nvs), 64'(38));
            chk("dut1 line_end per frame", 64'(nle), 64'(10));
        end
    endtask

    initial begin
        #2;
        chk("reset state dut0", 64'({x0, y0, req0, hs0, vs0, val0, fs0, le0, rgb0}),
            64'(model_out(cfg0, 0, 16'h0000, 1'b1)));
        chk("reset state dut1", 64'({x1, y1, req1, hs1, vs1, val1, fs1, le1, rgb1}),
            64'(model_out(cfg1, 0, pd1, 1'b0)));
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        #3;
        fork
            default_seq();
            small_seq();
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
